// File: rtl/mp_addsub_seq_pkg.sv
// Shared constants and types for the multi-precision add/sub sequencer.
//   OP_*    : request opcode encoding (0 = add, 1 = subtract)
//   SEL_*   : one-hot select driven to the 32-bit add/sub unit
//   state_t : sequencer FSM states
package addsub_pkg;
    localparam int         WORD_W  = 32;
    localparam logic       OP_ADD  = 1'b0;
    localparam logic       OP_SUB  = 1'b1;
    localparam logic [1:0] SEL_ADD = 2'b01;
    localparam logic [1:0] SEL_SUB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mp_addsub_seq_if.sv
// Request/response handshake bundle for the multi-precision add/sub sequencer.
//   req_valid/req_ready/req_op/req_a/req_b : wide operand request (valid/ready)
//   rsp_valid/rsp_ready/rsp_z/rsp_*        : wide result plus flags (valid/ready)
// slave  : the sequencer side; master : the requester/consumer side.
interface mp_addsub_seq_if
    import addsub_pkg::*;
#(
    parameter int NWORDS = 2
);
    localparam int W = WORD_W * NWORDS;

    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_z;
    logic         rsp_carry;
    logic         rsp_overflow;
    logic         rsp_negative;
    logic         rsp_zero;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_carry, rsp_overflow,
               rsp_negative, rsp_zero
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_carry, rsp_overflow,
               rsp_negative, rsp_zero
    );
endinterface

// File: rtl/addsub32.sv
// 32-bit combinational add/subtract unit.
//   a, b      : operands
//   sel       : 2'b01 add (a + b + cin), 2'b10 subtract (a - b - bin)
//   cin, bin  : carry-in / borrow-in
//   z         : result word
//   cout      : carry-out, high-impedance unless sel[0]
//   bout      : borrow-out, high-impedance unless sel[1]
//   overflow  : signed overflow of the selected operation
//   negative  : z[31]
//   zero      : z == 0
module addsub32
    import addsub_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [1:0]        sel,
    input  logic              cin,
    input  logic              bin,
    output logic [WORD_W-1:0] z,
    output logic              cout,
    output logic              bout,
    output logic              overflow,
    output logic              negative,
    output logic              zero
);
    logic [WORD_W:0] w_sum;
    logic [WORD_W:0] w_dif;

    assign w_sum = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
    // The 33rd bit of a zero-extended difference is the borrow-out.
    assign w_dif = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, bin};

    assign z        = sel[1] ? w_dif[WORD_W-1:0] : w_sum[WORD_W-1:0];
    assign cout     = sel[0] ? w_sum[WORD_W] : 1'bz;
    assign bout     = sel[1] ? w_dif[WORD_W] : 1'bz;
    assign overflow = sel[1] ? ((a[WORD_W-1] != b[WORD_W-1]) && (z[WORD_W-1] != a[WORD_W-1]))
                             : ((a[WORD_W-1] == b[WORD_W-1]) && (z[WORD_W-1] != a[WORD_W-1]));
    assign negative = z[WORD_W-1];
    assign zero     = (z == '0);
endmodule

// File: rtl/mp_addsub_top.sv
module mp_addsub_top
  import addsub_pkg::*;
#(
  parameter int NWORDS = 2
)(
  input  logic           clk,
  input  logic           rst_n,
  mp_addsub_seq_if.slave bus
);
  logic [WORD_W-1:0] w_alu_a, w_alu_b, w_alu_z;
  logic [1:0]        w_alu_sel;
  logic              w_alu_cin, w_alu_bin;
  logic              w_alu_cout, w_alu_bout;
  logic              w_alu_ovf, w_alu_neg, w_alu_zero;

  mp_addsub_seq #(.NWORDS(NWORDS)) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (bus.req_valid),
    .req_ready    (bus.req_ready),
    .req_op       (bus.req_op),
    .req_a        (bus.req_a),
    .req_b        (bus.req_b),
    .rsp_valid    (bus.rsp_valid),
    .rsp_ready    (bus.rsp_ready),
    .rsp_z        (bus.rsp_z),
    .rsp_carry    (bus.rsp_carry),
    .rsp_overflow (bus.rsp_overflow),
    .rsp_negative (bus.rsp_negative),
    .rsp_zero     (bus.rsp_zero),
    .alu_a        (w_alu_a),
    .alu_b        (w_alu_b),
    .alu_sel      (w_alu_sel),
    .alu_cin      (w_alu_cin),
    .alu_bin      (w_alu_bin),
    .alu_z        (w_alu_z),
    .alu_cout     (w_alu_cout),
    .alu_bout     (w_alu_bout),
    .alu_overflow (w_alu_ovf),
    .alu_negative (w_alu_neg),
    .alu_zero     (w_alu_zero)
  );

  addsub32 u_alu (
    .a        (w_alu_a),
    .b        (w_alu_b),
    .sel      (w_alu_sel),
    .cin      (w_alu_cin),
    .bin      (w_alu_bin),
    .z        (w_alu_z),
    .cout     (w_alu_cout),
    .bout     (w_alu_bout),
    .overflow (w_alu_ovf),
    .negative (w_alu_neg),
    .zero     (w_alu_zero)
  );
endmodule

// File: rtl/mp_addsub_seq.sv
module mp_addsub_seq
  import addsub_pkg::*;
#(
  parameter int NWORDS = 2
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_op,
  input  logic [WORD_W*NWORDS-1:0] req_a,
  input  logic [WORD_W*NWORDS-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WORD_W*NWORDS-1:0] rsp_z,
  output logic                     rsp_carry,
  output logic                     rsp_overflow,
  output logic                     rsp_negative,
  output logic                     rsp_zero,
  output logic [WORD_W-1:0]        alu_a,
  output logic [WORD_W-1:0]        alu_b,
  output logic [1:0]               alu_sel,
  output logic                     alu_cin,
  output logic                     alu_bin,
  input  logic [WORD_W-1:0]        alu_z,
  input  logic                     alu_cout,
  input  logic                     alu_bout,
  input  logic                     alu_overflow,
  input  logic                     alu_negative,
  input  logic                     alu_zero
);
  localparam int W    = WORD_W * NWORDS;
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_a, r_b, r_z;
  logic            r_op;
  logic [IDXW-1:0] r_idx;
  logic            r_chain;
  logic            r_zacc;
  logic            r_carry, r_ovf, r_neg, r_zero;
  logic            w_cy;
  logic            w_last;
  logic            w_unused;

  assign w_unused = alu_negative;
  assign w_cy     = r_op ? alu_bout : alu_cout;
  assign w_last   = (r_idx == IDXW'(NWORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = SEL_ADD;
    alu_cin     = 1'b0;
    alu_bin     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = RUN;
      end
      RUN: begin
        alu_a   = r_a[r_idx*WORD_W +: WORD_W];
        alu_b   = r_b[r_idx*WORD_W +: WORD_W];
        alu_sel = (r_op == OP_SUB) ? SEL_SUB : SEL_ADD;
        alu_cin = (r_op == OP_ADD) & r_chain;
        alu_bin = (r_op == OP_SUB) & r_chain;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_idx   <= '0;
      r_chain <= 1'b0;
      r_zacc  <= 1'b0;
      r_z     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_a     <= req_a;
          r_b     <= req_b;
          r_op    <= req_op;
          r_idx   <= '0;
          r_chain <= 1'b0;
          r_zacc  <= 1'b1;
        end
        RUN: begin
          r_z[r_idx*WORD_W +: WORD_W] <= alu_z;
          r_zacc  <= r_zacc & alu_zero;
          r_chain <= w_cy;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_carry <= w_cy;
            r_ovf   <= alu_overflow;
            r_neg   <= alu_z[WORD_W-1];
            r_zero  <= r_zacc & alu_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_z        = r_z;
  assign rsp_carry    = r_carry;
  assign rsp_overflow = r_ovf;
  assign rsp_negative = r_neg;
  assign rsp_zero     = r_zero;
endmodule

// File: tb/tb_mp_addsub_seq.sv
module tb_mp_addsub_seq;
  localparam int NW = 2;
  localparam int W  = 32 * NW;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  mp_addsub_seq_if #(.NWORDS(NW)) bus();

  mp_addsub_top #(.NWORDS(NW)) u_top (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic          d_req_ready, d_rsp_valid;
  logic [W-1:0]  d_rsp_z;
  logic          d_rsp_carry, d_rsp_ovf, d_rsp_neg, d_rsp_zero;
  logic [31:0]   d_alu_a, d_alu_b, d_alu_z;
  logic [1:0]    d_alu_sel;
  logic          d_alu_cin, d_alu_bin, d_alu_cout, d_alu_bout;
  logic          d_alu_ovf, d_alu_neg, d_alu_zero;

  mp_addsub_seq #(.NWORDS(NW)) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (bus.req_valid),
    .req_ready    (d_req_ready),
    .req_op       (bus.req_op),
    .req_a        (bus.req_a),
    .req_b        (bus.req_b),
    .rsp_valid    (d_rsp_valid),
    .rsp_ready    (bus.rsp_ready),
    .rsp_z        (d_rsp_z),
    .rsp_carry    (d_rsp_carry),
    .rsp_overflow (d_rsp_ovf),
    .rsp_negative (d_rsp_neg),
    .rsp_zero     (d_rsp_zero),
    .alu_a        (d_alu_a),
    .alu_b        (d_alu_b),
    .alu_sel      (d_alu_sel),
    .alu_cin      (d_alu_cin),
    .alu_bin      (d_alu_bin),
    .alu_z        (d_alu_z),
    .alu_cout     (d_alu_cout),
    .alu_bout     (d_alu_bout),
    .alu_overflow (d_alu_ovf),
    .alu_negative (d_alu_neg),
    .alu_zero     (d_alu_zero)
  );

  addsub32 u_seq_alu (
    .a        (d_alu_a),
    .b        (d_alu_b),
    .sel      (d_alu_sel),
    .cin      (d_alu_cin),
    .bin      (d_alu_bin),
    .z        (d_alu_z),
    .cout     (d_alu_cout),
    .bout     (d_alu_bout),
    .overflow (d_alu_ovf),
    .negative (d_alu_neg),
    .zero     (d_alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ez,
                        input logic ec, input logic eo, input logic en, input logic ezr);
    @(negedge clk);
    chk({tag, ".req_ready"}, W'(bus.req_ready), W'(1'b1));
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk({tag, ".alu_sel"}, W'(u_top.w_alu_sel), op ? W'(2'b10) : W'(2'b01));
    chk({tag, ".busy"}, W'(bus.req_ready), W'(1'b0));
    @(posedge clk); #1;
    chk({tag, ".lat1"}, W'(bus.rsp_valid), W'(1'b0));
    @(posedge clk); #1;
    chk({tag, ".lat2"}, W'(bus.rsp_valid), W'(1'b1));
    chk({tag, ".z"}, bus.rsp_z, ez);
    chk({tag, ".carry"}, W'(bus.rsp_carry), W'(ec));
    chk({tag, ".ovf"}, W'(bus.rsp_overflow), W'(eo));
    chk({tag, ".neg"}, W'(bus.rsp_negative), W'(en));
    chk({tag, ".zero"}, W'(bus.rsp_zero), W'(ezr));
    chk({tag, ".seq_valid"}, W'(d_rsp_valid), W'(1'b1));
    chk({tag, ".seq_z"}, d_rsp_z, ez);
    chk({tag, ".seq_carry"}, W'(d_rsp_carry), W'(ec));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, ".drop"}, W'(bus.rsp_valid), W'(1'b0));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", W'(bus.req_ready), W'(1'b1));
    chk("rst.rsp_valid", W'(bus.rsp_valid), W'(1'b0));
    chk("rst.rsp_z", bus.rsp_z, '0);
    chk("rst.alu_sel", W'(u_top.w_alu_sel), W'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_cy",   1'b0, 64'h00000000_FFFFFFFF, 64'h1,
           64'h00000001_00000000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_bw",   1'b1, 64'h00000001_00000000, 64'h1,
           64'h00000000_FFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_0m1",  1'b1, 64'h0, 64'h1,
           64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("add_ovf",  1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1,
           64'h80000000_00000000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("add_wrap", 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h1,
           64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("add_5",    1'b0, 64'h5, 64'h0,
           64'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_eq",   1'b1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0,
           64'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_a     = 64'h00000002_00000003;
    bus.req_b     = 64'h00000004_00000005;
    @(posedge clk); #1;
    bus.req_a     = 64'hAAAAAAAA_AAAAAAAA;
    bus.req_b     = 64'h11111111_11111111;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold.valid", W'(bus.rsp_valid), W'(1'b1));
      chk("hold.z", bus.rsp_z, 64'h00000006_00000008);
      chk("hold.req_ready", W'(bus.req_ready), W'(1'b0));
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("hold.drop", W'(bus.rsp_valid), W'(1'b0));
    chk("hold.keep_z", bus.rsp_z, 64'h00000006_00000008);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.no_extra", W'(bus.rsp_valid), W'(1'b0));

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_a     = 64'h5;
    bus.req_b     = 64'h3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("mid.alu_sel_run", W'(u_top.w_alu_sel), W'(2'b10));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.rsp_valid", W'(bus.rsp_valid), W'(1'b0));
    chk("mid.alu_sel", W'(u_top.w_alu_sel), W'(2'b01));
    chk("mid.rsp_z", bus.rsp_z, '0);
    chk("mid.seq_alu_sel", W'(d_alu_sel), W'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid.req_ready", W'(bus.req_ready), W'(1'b1));
    chk("mid.seq_req_ready", W'(d_req_ready), W'(1'b1));
    @(posedge clk); #1;
    chk("mid.no_rsp", W'(bus.rsp_valid), W'(1'b0));

    run_op("post_rst", 1'b1, 64'h5, 64'h3,
           64'h2, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
